io_port_controller: RTL and testbench

IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

---
 rtl/io_port_controller.sv | 149 ++++++++++++++
 tb/tb_io_port_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_controller.sv
// io_port_controller: MMIO window (PORTOUT/PORTIN/STATUS) at IO_BASE; PortOut registered, ReadData combinational.
// PortIn is synchronized; define IO_PORT_DEBOUNCE_EN to qualify changes for DEBOUNCE_CYCLES samples.
module io_port_controller #(
  parameter logic [31:0] IO_BASE         = 32'h1001_0020,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic [31:0] PortOut,
  output logic        PortInChanged
);

  localparam logic [1:0] OFF_PORTOUT = 2'd0;
  localparam logic [1:0] OFF_PORTIN  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("io_port_controller: DEBOUNCE_CYCLES must be within 2..255");
  end

  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_wr_portout;
  logic        w_clr_flag;
  logic        w_set_flag;
  logic        w_unused_addr;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_pin_stable;
  logic        r_flag;
  logic [31:0] r_port_out;

  // Byte lane bits are don't-care: every register is a full word.
  assign w_unused_addr = ^Address[1:0];

  assign w_hit        = (Address[31:4] == IO_BASE[31:4]);
  assign w_off        = Address[3:2];
  assign w_wr_portout = w_hit && MemWrite && (w_off == OFF_PORTOUT);
  assign w_clr_flag   = w_hit && MemWrite && (w_off == OFF_STATUS) && WriteData[0];

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && w_hit) begin
      case (w_off)
        OFF_PORTOUT: ReadData = r_port_out;
        OFF_PORTIN:  ReadData = {24'h0, r_pin_stable};
        OFF_STATUS:  ReadData = {31'h0, r_flag};
        default:     ReadData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= 32'h0;
      r_sync1    <= 8'h0;
      r_sync2    <= 8'h0;
      r_flag     <= 1'b0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      if (w_wr_portout) r_port_out <= WriteData;
      // A new acceptance outranks a software clear in the same cycle.
      if (w_set_flag)      r_flag <= 1'b1;
      else if (w_clr_flag) r_flag <= 1'b0;
    end
  end

`ifdef IO_PORT_DEBOUNCE_EN
  typedef enum logic {S_IDLE, S_COUNT} state_t;
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] r_cand;
  logic [7:0] w_cand_nxt;
  logic       w_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'h0;
      r_cand       <= 8'h0;
      r_pin_stable <= 8'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      if (w_accept) r_pin_stable <= r_cand;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sync2 != r_pin_stable) begin
          w_cand_nxt  = r_sync2;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (r_sync2 == r_cand) begin
          if (r_cnt == LAST_CNT) begin
            w_accept    = 1'b1;
            w_cnt_nxt   = 8'h0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end else if (r_sync2 == r_pin_stable) begin
          w_cnt_nxt   = 8'h0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The candidate always differs from PinStable, so every acceptance is a change.
  assign w_set_flag = w_accept;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pin_stable <= 8'h0;
    else        r_pin_stable <= r_sync2;
  end

  assign w_set_flag = (r_sync2 != r_pin_stable);
`endif

  assign PortOut       = r_port_out;
  assign PortInChanged = r_flag;

endmodule

// File: tb/tb_io_port_controller.sv
// Bench for io_port_controller: directed literal checks plus randomized traffic against a behavioural model.
// Follows IO_PORT_DEBOUNCE_EN the same way the design does.
module tb_io_port_controller;
  localparam logic [31:0] BASE = 32'h1001_0020;
  localparam int D = 4;
`ifdef IO_PORT_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [7:0]  PortIn = 8'h0;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
  logic        PortInChanged;

  int n_pass = 0;
  int n_tot  = 0;

  io_port_controller #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
    .ReadData(ReadData), .PortOut(PortOut), .PortInChanged(PortInChanged)
  );

  always #5 clk = ~clk;

  // Model: p0/p1 are PortIn samples from two and one edges ago; run counts
  // consecutive identical samples that differ from the accepted value.
  typedef struct packed {
    logic [31:0] out;
    logic [7:0]  stable;
    logic        flag;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  cand;
    logic [8:0]  run;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t m_next(input mstate_t c);
    mstate_t    n;
    logic [7:0] s;
    logic       set;
    logic       hit;
    n   = c;
    set = 1'b0;
    hit = (Address[31:4] == BASE[31:4]);
    s    = c.p0;
    n.p0 = c.p1;
    n.p1 = PortIn;
`ifdef IO_PORT_DEBOUNCE_EN
    if (s == c.stable) n.run = 9'd0;
    else if (c.run != 9'd0 && s == c.cand) n.run = c.run + 9'd1;
    else begin
      n.cand = s;
      n.run  = 9'd1;
    end
    if (n.run == 9'(D)) begin
      n.stable = n.cand;
      n.run    = 9'd0;
      set      = 1'b1;
    end
`else
    set      = (s != c.stable);
    n.stable = s;
`endif
    if (hit && MemWrite && Address[3:2] == 2'd0) n.out = WriteData;
    if (set) n.flag = 1'b1;
    else if (hit && MemWrite && Address[3:2] == 2'd2 && WriteData[0]) n.flag = 1'b0;
    return n;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!MemRead || Address[31:4] != BASE[31:4]) return 32'h0;
    case (Address[3:2])
      2'd0:    return m.out;
      2'd1:    return {24'h0, m.stable};
      2'd2:    return {31'h0, m.flag};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= m_next(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("cmp_readdata", ReadData, m_rdata());
    chk("cmp_portout", PortOut, m.out);
    chk1("cmp_changed", PortInChanged, m.flag);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int hold;
    MemRead = 1'b1;
    Address = BASE;
    #1 reset = 1'b0;
    #1;
    chk("reset_rdata", ReadData, 32'h0);
    chk("reset_portout", PortOut, 32'h0);
    tick();
    tick();
    reset = 1'b1;

    for (int o = 0; o < 3; o++) begin
      Address = BASE + 32'(o * 4);
      #1 chk("init_read", ReadData, 32'h0);
    end
    chk("init_portout", PortOut, 32'h0);
    chk1("init_flag", PortInChanged, 1'b0);

    MemWrite = 1'b1; Address = BASE; WriteData = 32'hDEAD_BEEF;
    #1 chk("wr_same_cycle_read", ReadData, 32'h0);
    tick();
    MemWrite = 1'b0;
    #1;
    chk("portout_after_wr", PortOut, 32'hDEAD_BEEF);
    chk("read_after_wr", ReadData, 32'hDEAD_BEEF);
    Address = BASE + 32'd1;
    #1 chk("unaligned_read", ReadData, 32'hDEAD_BEEF);
    MemRead = 1'b0; Address = BASE;
    #1 chk("no_read_strobe", ReadData, 32'h0);

    MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'h1234; Address = BASE + 32'd4;
    tick();
    Address = BASE + 32'd16;
    tick();
    MemWrite = 1'b0; Address = BASE + 32'd12;
    #1;
    chk("portout_unchanged", PortOut, 32'hDEAD_BEEF);
    chk("reserved_read", ReadData, 32'h0);

    Address = BASE + 32'd4; PortIn = 8'hA5;
    for (int n = 1; n <= LAT; n++) begin
      tick();
      #1;
      chk("lat_portin", ReadData, (n == LAT) ? 32'hA5 : 32'h0);
      chk1("lat_flag", PortInChanged, n == LAT);
    end

    MemWrite = 1'b1; Address = BASE + 32'd8; WriteData = 32'h0;
    tick();
    chk1("w0_no_clear", PortInChanged, 1'b1);
    WriteData = 32'h1;
    tick();
    MemWrite = 1'b0;
    chk1("w1_clear", PortInChanged, 1'b0);
    PortIn = 8'h5A;
    for (int n = 1; n < LAT; n++) tick();
    chk1("pre_accept_flag", PortInChanged, 1'b0);
    MemWrite = 1'b1; Address = BASE + 32'd8; WriteData = 32'h1;
    tick();
    MemWrite = 1'b0;
    chk1("set_beats_clear", PortInChanged, 1'b1);
    Address = BASE + 32'd4;
    #1 chk("portin_5a", ReadData, 32'h5A);

    MemWrite = 1'b1; Address = BASE + 32'd8; WriteData = 32'h1;
    tick();
    MemWrite = 1'b0;
`ifdef IO_PORT_DEBOUNCE_EN
    PortIn = 8'h3C;
    tick();
    tick();
    PortIn = 8'h5A;
    repeat (12) tick();
    chk1("glitch_flag", PortInChanged, 1'b0);
`else
    PortIn = 8'h3C;
    tick();
    PortIn = 8'h5A;
    repeat (8) tick();
    chk1("glitch_flag", PortInChanged, 1'b1);
`endif
    Address = BASE + 32'd4;
    #1 chk("glitch_portin", ReadData, 32'h5A);

    PortIn = 8'hC3;
    tick();
    tick();
    tick();
    reset = 1'b0; PortIn = 8'h00;
    #1;
    chk("async_reset_portout", PortOut, 32'h0);
    chk1("async_reset_flag", PortInChanged, 1'b0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk1("post_reset_flag", PortInChanged, 1'b0);
    #1 chk("post_reset_portin", ReadData, 32'h0);

    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        PortIn = 8'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      MemRead   = 1'($urandom);
      MemWrite  = ($urandom_range(0, 3) == 0);
      WriteData = $urandom;
      case ($urandom_range(0, 4))
        0, 1, 2: Address = {BASE[31:4], 2'($urandom_range(0, 3)), 2'($urandom)};
        3:       Address = {BASE[31:4] + 28'd1, 4'($urandom)};
        default: Address = $urandom;
      endcase
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
